// File: rtl/some_sub_module.sv
// Two-entry valid/ready skid buffer with a wrapping running sum and a
// saturating count of accepted samples. in_ready depends only on registered state.
module some_sub_module #(
  parameter int W_DATA = 4,
  parameter int W_CNT  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              a,
  output logic              b,
  input  logic [W_DATA-1:0] c,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [W_DATA-1:0] o_data,
  output logic [W_DATA+3:0] o_sum,
  output logic [W_CNT-1:0]  o_count
);

  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [W_DATA+3:0] wrap_add(input logic [W_DATA+3:0] s,
                                                input logic [W_DATA-1:0] x);
    return s + {4'b0000, x};
  endfunction

  logic [W_DATA-1:0] mem_p0 [2];
  logic [1:0]        occ_p0;
  logic              head_p0;
  logic              tail_p0;

  logic              push;
  logic              pop;
  logic              nxt_head;
  logic [1:0]        nxt_occ;
  logic [W_DATA-1:0] nxt_head_data;

  assign b       = (occ_p0 != 2'd2) && !i_rst;
  assign o_valid = (occ_p0 != 2'd0);
  assign push    = a && b;
  assign pop     = o_valid && i_ready;

  // The head seen next cycle is the incoming sample only when the buffer drains to it.
  always_comb begin
    nxt_head      = head_p0 ^ pop;
    nxt_occ       = occ_p0 + {1'b0, push} - {1'b0, pop};
    nxt_head_data = mem_p0[nxt_head];
    if (push && (tail_p0 == nxt_head)) nxt_head_data = c;
  end

  // Stage p0: storage, pointers and accumulators
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_p0[0] <= '0;
      mem_p0[1] <= '0;
      occ_p0    <= 2'd0;
      head_p0   <= 1'b0;
      tail_p0   <= 1'b0;
      o_data    <= '0;
      o_sum     <= '0;
      o_count   <= '0;
    end else begin
      if (push) begin
        mem_p0[tail_p0] <= c;
        tail_p0         <= ~tail_p0;
        o_sum           <= wrap_add(o_sum, c);
        o_count         <= sat_inc(o_count);
      end
      if (pop) head_p0 <= ~head_p0;
      occ_p0 <= nxt_occ;
      if (nxt_occ != 2'd0) o_data <= nxt_head_data;
    end
  end

endmodule

// File: tb/tb_some_sub_module.sv
// Randomised and directed bench for some_sub_module against a queue-based model.
module tb_some_sub_module;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       a;
  logic       b;
  logic [3:0] c;
  logic       i_ready;
  logic       o_valid;
  logic [3:0] o_data;
  logic [7:0] o_sum;
  logic [3:0] o_count;

  some_sub_module #(.W_DATA(4), .W_CNT(4)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_sum  (o_sum),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int q[$];
  int m_sum    = 0;
  int m_cnt    = 0;
  int m_shown  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model follows the valid/ready rules directly.
  task automatic step(input bit av, input int cv, input bit rv);
    bit ep;
    bit eo;
    a = av;
    c = 4'(cv);
    i_ready = rv;
    #1;
    chk("b", b, (q.size() != 2));
    ep = av && (q.size() < 2);
    eo = (q.size() > 0) && rv;
    @(posedge i_clk);
    #1;
    if (eo) void'(q.pop_front());
    if (ep) begin
      q.push_back(cv & 15);
      m_sum = (m_sum + (cv & 15)) % 256;
      if (m_cnt < 15) m_cnt++;
    end
    if (q.size() > 0) m_shown = q[0];
    chk("o_valid", o_valid, (q.size() > 0));
    chk("o_data", o_data, m_shown);
    chk("o_sum", o_sum, m_sum);
    chk("o_count", o_count, m_cnt);
  endtask

  task automatic hit_reset();
    a = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_b", b, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_sum", o_sum, 0);
    chk("rst_o_count", o_count, 0);
    q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_shown = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    a = 1'b0;
    c = 4'd0;
    i_ready = 1'b0;
    #3;
    chk("init_b", b, 0);
    chk("init_o_valid", o_valid, 0);
    chk("init_o_sum", o_sum, 0);
    chk("init_o_count", o_count, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // single transfer
    step(1, 10, 1);
    chk("single_data", o_data, 10);
    step(0, 0, 1);
    chk("single_sum", o_sum, 10);
    chk("single_cnt", o_count, 1);
    hit_reset();

    // back-pressure to full, then drain in order
    step(1, 3, 0);
    step(1, 5, 0);
    step(1, 7, 0);
    chk("full_cnt", o_count, 2);
    chk("full_sum", o_sum, 8);
    step(0, 0, 1);
    chk("drain_second", o_data, 5);
    step(0, 0, 1);
    step(0, 0, 1);
    hit_reset();

    // reach occ=2 with sum 37, then reset mid-stream
    step(1, 15, 1);
    step(1, 15, 1);
    step(1, 7, 0);
    chk("pre_rst_sum", o_sum, 37);
    hit_reset();

    // streaming 1..15
    for (int i = 1; i <= 15; i++) step(1, i, 1);
    step(0, 0, 1);
    chk("stream_sum", o_sum, 120);
    chk("stream_cnt", o_count, 15);
    hit_reset();

    // wrap and saturation
    for (int i = 0; i < 20; i++) step(1, 15, 1);
    chk("wrap_sum", o_sum, 44);
    chk("sat_cnt", o_count, 15);
    hit_reset();

    // simultaneous push/pop at occ=1
    step(1, 2, 0);
    step(1, 9, 1);
    chk("pp_head", o_data, 9);
    step(1, 4, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    hit_reset();

    // randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ((i % 150) == 149) hit_reset();
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/some_sub_module.md
Name: some_sub_module

Overview:
Two-entry valid/ready pipeline buffer for W_DATA-bit samples, with a running sum and a count of accepted samples. It sits between a producer (in_valid/in_ready/data) and a downstream consumer inside pipe_pal-style datapaths. It registers the input and has no combinational path from i_ready to in_ready.

Parameters:
W_DATA, 4, sample width in bits (minimum 1).
W_CNT, 8, width of the accepted-sample counter.

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  asynchronous reset, active-high
a  input  1  in_valid: producer offers sample on c
b  output  1  in_ready: buffer can take a sample this cycle
c  input  W_DATA  sample data
i_ready  input  1  consumer ready
o_valid  output  1  head entry valid
o_data  output  W_DATA  head entry data
o_sum  output  W_DATA+4  running sum of accepted samples
o_count  output  W_CNT  number of accepted samples, saturating

Behaviour:
- Reset (async assert, sync release on i_clk): both entries empty; o_valid=0; o_data=0; o_sum=0; o_count=0; b=0 while i_rst=1.
- Storage: 2-entry FIFO with occupancy occ in {0,1,2}. Head pointer and tail pointer are 1 bit each and wrap 1->0.
- b = (occ != 2) and not i_rst. Decoded from registered state only; independent of i_ready.
- push = a & b. pop = o_valid & i_ready.
- On push, c is written at the tail. A pushed sample appears on o_data/o_valid the next cycle when occ was 0 (latency 1 cycle).
- o_valid = (occ != 0). o_data = head entry. o_data holds its last value when empty, except that it is 0 after reset.
- Occupancy update:
  - push only: occ+1.
  - pop only: occ-1.
  - push and pop together: occ unchanged, pointers both advance.
  - push at occ=0 with i_ready=1: no pop that cycle because o_valid=0.
- Full (occ=2): b=0; a is ignored and no data is lost. A pop while full drops occ to 1, and b rises the next cycle.
- Empty (occ=0): i_ready is ignored and o_valid=0.
- o_valid/o_data must stay stable while o_valid=1 and i_ready=0.
- o_sum: on each push, o_sum <= o_sum + zero-extended c, modulo 2^(W_DATA+4) (wraps silently). Visible the cycle after the push.
- o_count: on each push, increments by 1 and saturates at 2^W_CNT-1.
- Reset mid-operation: all contents are discarded immediately (async), and outputs return to reset values.
- a/c may change while b=0 without effect. X on c when a=0 must not affect o_sum.

Test Plan:
- Reset: assert i_rst mid-stream with occ=2, o_sum=37 -> o_valid=0, o_sum=0, o_count=0, b=0 immediately. b=1 on the first edge after release.
- Single transfer: c=4'hA, a=1 one cycle, i_ready=1 -> o_valid=1 with o_data=4'hA next cycle, then 0. o_sum=10, o_count=1.
- Back-pressure/full: i_ready=0, push 3,5,7 on consecutive cycles -> b=0 after the second push, 7 not accepted, o_count=2, o_sum=8. Then i_ready=1 -> outputs 3 then 5, in order.
- Streaming: a=1, i_ready=1 continuously, c=1..15 -> each sample out exactly 1 cycle later, b stays 1, o_sum=120, o_count=15.
- Wrap/saturation: push 4'hF 20 times (W_DATA=4) -> o_sum = 300 mod 256 = 44. With W_CNT=4, o_count saturates at 15.
- Simultaneous push/pop at occ=1: occ stays 1, o_data advances to the new sample after the head, and no duplicate or lost samples occur.
